bp_nonsynth_commit_gen: RTL and testbench

BP_NONSYNTH_COMMIT_GEN -- requirements
Module: bp_nonsynth_commit_gen

---
 rtl/bp_be_pkg.sv | 12 +
 rtl/bp_nonsynth_commit_gen_lfsr.sv | 21 ++
 rtl/bp_nonsynth_commit_gen.sv | 90 +++++++++
 tb/tb_bp_nonsynth_commit_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared types for the nonsynth commit generator.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_run,
        e_done
    } bp_commit_gen_state_e;

    localparam int commit_count_width_gp = 64;

endpackage

// File: rtl/bp_nonsynth_commit_gen_lfsr.sv
// bp_nonsynth_commit_gen_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with hold enable.
module bp_nonsynth_commit_gen_lfsr #(
    parameter logic [15:0] seed_p = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign state_o = lfsr_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) lfsr_q <= seed_p;
        else if (en_i) lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/bp_nonsynth_commit_gen.sv
// bp_nonsynth_commit_gen: replays trace entries (start pc, run length) as one commit per cycle,
// with optional LFSR-driven bubbles.
module bp_nonsynth_commit_gen
    import bp_be_pkg::*;
#(
    parameter int          vaddr_width_p = 39,
    parameter int          len_width_p   = 16,
    parameter int          bubble_rate_p = 0,
    parameter logic [15:0] lfsr_seed_p   = 16'hACE1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 freeze_i,
    input  logic                                 trace_v_i,
    input  logic [vaddr_width_p-1:0]             trace_pc_i,
    input  logic [len_width_p-1:0]               trace_len_i,
    input  logic                                 trace_last_i,
    output logic                                 trace_ready_o,
    output logic                                 commit_v_o,
    output logic [vaddr_width_p-1:0]             commit_pc_o,
    output logic [commit_count_width_gp-1:0]     commit_count_o,
    output logic                                 finish_o
);

    localparam logic [3:0] rate_l = 4'(bubble_rate_p);

    bp_commit_gen_state_e             state_q, state_d;
    logic [vaddr_width_p-1:0]         pc_q, pc_d;
    logic [len_width_p-1:0]           remain_q, remain_d;
    logic                             last_q, last_d;
    logic [commit_count_width_gp-1:0] count_q, count_d;
    logic [15:0]                      lfsr;
    logic                             bubble, fire, final_commit, accept;

    bp_nonsynth_commit_gen_lfsr #(.seed_p(lfsr_seed_p)) lfsr_u (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .en_i     (!freeze_i),
        .state_o  (lfsr)
    );

    assign bubble        = (rate_l != 4'd0) && (lfsr[3:0] < rate_l);
    assign fire          = (state_q == e_run) && !freeze_i && !bubble;
    assign final_commit  = fire && (remain_q == len_width_p'(1));
    // Gating with reset keeps every output low while reset is held.
    assign trace_ready_o = reset_n_i && !freeze_i && ((state_q == e_idle) || (final_commit && !last_q));
    assign accept        = trace_v_i && trace_ready_o;

    assign commit_v_o     = fire;
    assign commit_pc_o    = pc_q;
    assign commit_count_o = count_q;
    assign finish_o       = (state_q == e_done);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        remain_d = remain_q;
        last_d   = last_q;
        count_d  = count_q;
        if (fire) begin
            pc_d     = pc_q + vaddr_width_p'(4);
            remain_d = remain_q - len_width_p'(1);
            count_d  = count_q + 64'd1;
            if (final_commit) state_d = last_q ? e_done : e_idle;
        end
        if (accept) begin
            pc_d     = trace_pc_i;
            remain_d = trace_len_i;
            last_d   = trace_last_i;
            state_d  = (trace_len_i != '0) ? e_run : (trace_last_i ? e_done : e_idle);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            pc_q     <= '0;
            remain_q <= '0;
            last_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            remain_q <= remain_d;
            last_q   <= last_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_commit_gen.sv
// tb_bp_nonsynth_commit_gen: directed scenarios for the commit generator, plus a bubble run
// checked against a reference LFSR.
module tb_bp_nonsynth_commit_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, freeze, v, last, ready, cv, fin;
    logic [38:0] pc, cpc;
    logic [15:0] len;
    logic [63:0] cnt;

    logic        rst2_n, freeze2, v2, last2, ready2, cv2, fin2;
    logic [38:0] pc2, cpc2;
    logic [15:0] len2;
    logic [63:0] cnt2;

    int total = 0;
    int bad   = 0;

    bp_nonsynth_commit_gen dut (
        .clk_i(clk), .reset_n_i(rst_n), .freeze_i(freeze), .trace_v_i(v),
        .trace_pc_i(pc), .trace_len_i(len), .trace_last_i(last), .trace_ready_o(ready),
        .commit_v_o(cv), .commit_pc_o(cpc), .commit_count_o(cnt), .finish_o(fin)
    );

    bp_nonsynth_commit_gen #(.bubble_rate_p(8)) dut_b (
        .clk_i(clk), .reset_n_i(rst2_n), .freeze_i(freeze2), .trace_v_i(v2),
        .trace_pc_i(pc2), .trace_len_i(len2), .trace_last_i(last2), .trace_ready_o(ready2),
        .commit_v_o(cv2), .commit_pc_o(cpc2), .commit_count_o(cnt2), .finish_o(fin2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; freeze = 1'b0; v = 1'b0; pc = '0; len = '0; last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++;
        if (cv !== 1'b0 || fin !== 1'b0 || cnt !== 64'd0 || cpc !== 39'd0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: cv=%b fin=%b cnt=%0d pc=%h ready=%b, want 0 0 0 0 1", cv, fin, cnt, cpc, ready);
        end
        @(negedge clk); freeze = 1'b1; #1;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL freeze_idle_ready: got %b want 0", ready); end
        freeze = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        v = 1'b1; pc = 39'h80000000; len = 16'd3; last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); v = 1'b0; #1;
            total++;
            if (cv !== 1'b1 || cpc !== 39'h80000000 + 39'(4 * i)) begin
                bad++;
                $display("FAIL single_commit%0d: v=%b pc=%h want 1 %h", i, cv, cpc, 39'h80000000 + 39'(4 * i));
            end
        end
        @(negedge clk); #1;
        total++;
        if (cv !== 1'b0 || fin !== 1'b1 || cnt !== 64'd3 || ready !== 1'b0) begin
            bad++;
            $display("FAIL single_done: v=%b fin=%b cnt=%0d ready=%b want 0 1 3 0", cv, fin, cnt, ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [38:0] exp_pc [3];
        logic        exp_rdy [3];
        exp_pc  = '{39'h100, 39'h104, 39'h200};
        exp_rdy = '{1'b0, 1'b1, 1'b0};
        do_reset();
        v = 1'b1; pc = 39'h100; len = 16'd2; last = 1'b0;
        @(negedge clk);
        pc = 39'h200; len = 16'd1; last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) v = 1'b0;
            #1;
            total++;
            if (cv !== 1'b1 || cpc !== exp_pc[i] || ready !== exp_rdy[i]) begin
                bad++;
                $display("FAIL b2b_commit%0d: v=%b pc=%h ready=%b want 1 %h %b", i, cv, cpc, ready, exp_pc[i], exp_rdy[i]);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (fin !== 1'b1 || cnt !== 64'd3 || cv !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done: fin=%b cnt=%0d v=%b want 1 3 0", fin, cnt, cv);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        v = 1'b1; pc = 39'h7FFFFFFFFC; len = 16'd2; last = 1'b1;
        @(negedge clk); v = 1'b0; #1;
        total++;
        if (cv !== 1'b1 || cpc !== 39'h7FFFFFFFFC) begin
            bad++; $display("FAIL wrap_first: v=%b pc=%h want 1 7ffffffffc", cv, cpc);
        end
        @(negedge clk); #1;
        total++;
        if (cv !== 1'b1 || cpc !== 39'h0) begin
            bad++; $display("FAIL wrap_second: v=%b pc=%h want 1 0", cv, cpc);
        end
        @(negedge clk); #1;
        total++;
        if (fin !== 1'b1 || cnt !== 64'd2) begin
            bad++; $display("FAIL wrap_done: fin=%b cnt=%0d want 1 2", fin, cnt);
        end
    endtask

    task automatic test_zero_len;
        do_reset();
        v = 1'b1; pc = 39'h999; len = 16'd0; last = 1'b0;
        @(negedge clk);
        pc = 39'h40; len = 16'd1; last = 1'b1; #1;
        total++;
        if (cv !== 1'b0 || ready !== 1'b1 || fin !== 1'b0) begin
            bad++; $display("FAIL zero_len_idle: v=%b ready=%b fin=%b want 0 1 0", cv, ready, fin);
        end
        @(negedge clk); v = 1'b0; #1;
        total++;
        if (cv !== 1'b1 || cpc !== 39'h40) begin
            bad++; $display("FAIL zero_len_commit: v=%b pc=%h want 1 40", cv, cpc);
        end
        @(negedge clk); #1;
        total++;
        if (fin !== 1'b1 || cnt !== 64'd1 || cv !== 1'b0) begin
            bad++; $display("FAIL zero_len_done: fin=%b cnt=%0d v=%b want 1 1 0", fin, cnt, cv);
        end
    endtask

    task automatic test_freeze;
        do_reset();
        v = 1'b1; pc = 39'h1000; len = 16'd4; last = 1'b1;
        @(negedge clk); v = 1'b0; #1;
        total++;
        if (cv !== 1'b1 || cpc !== 39'h1000) begin
            bad++; $display("FAIL freeze_first: v=%b pc=%h want 1 1000", cv, cpc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); freeze = 1'b1; #1;
            total++;
            if (cv !== 1'b0 || ready !== 1'b0 || cpc !== 39'h1004 || cnt !== 64'd1) begin
                bad++; $display("FAIL freeze_hold%0d: v=%b ready=%b pc=%h cnt=%0d want 0 0 1004 1", i, cv, ready, cpc, cnt);
            end
        end
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); freeze = 1'b0; #1;
            total++;
            if (cv !== 1'b1 || cpc !== 39'h1000 + 39'(4 * i)) begin
                bad++; $display("FAIL freeze_resume%0d: v=%b pc=%h want 1 %h", i, cv, cpc, 39'h1000 + 39'(4 * i));
            end
        end
        @(negedge clk); #1;
        total++;
        if (fin !== 1'b1 || cnt !== 64'd4) begin
            bad++; $display("FAIL freeze_done: fin=%b cnt=%0d want 1 4", fin, cnt);
        end
    endtask

    task automatic test_bubble;
        logic [15:0] m;
        int          n, cyc;
        logic        exp_v;
        @(negedge clk);
        rst2_n = 1'b0; freeze2 = 1'b0; v2 = 1'b0; pc2 = '0; len2 = '0; last2 = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        m = 16'hACE1;
        v2 = 1'b1; pc2 = 39'h2000; len2 = 16'd100; last2 = 1'b1;
        m = lfsr_step(m);
        n = 0; cyc = 0;
        while (n < 100 && cyc < 1000) begin
            @(negedge clk); v2 = 1'b0; #1;
            exp_v = !(m[3:0] < 4'd8);
            total++;
            if (cv2 !== exp_v || (exp_v && cpc2 !== 39'h2000 + 39'(4 * n))) begin
                bad++; $display("FAIL bubble_cyc%0d: v=%b pc=%h want %b %h", cyc, cv2, cpc2, exp_v, 39'h2000 + 39'(4 * n));
            end
            if (exp_v) n++;
            m = lfsr_step(m);
            cyc++;
        end
        @(negedge clk); #1;
        total++;
        if (n != 100 || fin2 !== 1'b1 || cnt2 !== 64'd100 || cv2 !== 1'b0) begin
            bad++; $display("FAIL bubble_done: n=%0d fin=%b cnt=%0d v=%b want 100 1 100 0", n, fin2, cnt2, cv2);
        end
        rst2_n = 1'b0;
        @(negedge clk); rst2_n = 1'b1;
        v2 = 1'b1; pc2 = 39'h3000; len2 = 16'd100; last2 = 1'b1;
        @(negedge clk); v2 = 1'b0;
        repeat (20) @(negedge clk);
        rst2_n = 1'b0; #1;
        total++;
        if (cv2 !== 1'b0 || cpc2 !== 39'd0 || cnt2 !== 64'd0 || fin2 !== 1'b0 || ready2 !== 1'b0) begin
            bad++; $display("FAIL bubble_midreset: v=%b pc=%h cnt=%0d fin=%b ready=%b want all 0", cv2, cpc2, cnt2, fin2, ready2);
        end
        @(negedge clk); rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (cv2 !== 1'b0 || cnt2 !== 64'd0 || ready2 !== 1'b1) begin
                bad++; $display("FAIL bubble_after_reset%0d: v=%b cnt=%0d ready=%b want 0 0 1", i, cv2, cnt2, ready2);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0; v = 1'b0; pc = '0; len = '0; last = 1'b0;
        rst2_n = 1'b0; freeze2 = 1'b0; v2 = 1'b0; pc2 = '0; len2 = '0; last2 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_zero_len();
        test_freeze();
        test_bubble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
